// File: rtl/bcg_ram_arbiter_if.sv
// Bus bundle around the background RAM arbiter: fetcher port, CPU bus port,
// RAM macro port and the posted-write level.
interface bcg_ram_arbiter_if #(
  parameter int ADDR_W      = 13,
  parameter int DATA_W      = 8,
  parameter int WFIFO_DEPTH = 4
);
  localparam int LVL_W = $clog2(WFIFO_DEPTH) + 1;

  logic              vid_active;
  logic [ADDR_W-1:0] vid_addr;
  logic [DATA_W-1:0] vid_rdata;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ready;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic [LVL_W-1:0]  wfifo_level;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_q;

  // The arbiter side.
  modport slave (
    input  vid_active, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_q,
    output vid_rdata, cpu_ready, cpu_rvalid, cpu_rdata, wfifo_level,
           ram_addr, ram_we, ram_wdata
  );

  // The surrounding system: fetcher, CPU bridge and RAM macro.
  modport master (
    output vid_active, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_q,
    input  vid_rdata, cpu_ready, cpu_rvalid, cpu_rdata, wfifo_level,
           ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/bcg_ram_arbiter.sv
// Single-port background RAM arbiter: fetcher has absolute priority, CPU writes
// are posted and drained in blanking, CPU reads wait for all posted writes.
//   state  | meaning
//   R_IDLE | no read outstanding
//   R_WAIT | read latched, waiting for a blanking cycle to issue
//   R_DATA | read issued last cycle, ram_q holds the data
module bcg_ram_arbiter #(
  parameter int ADDR_W      = 13,
  parameter int DATA_W      = 8,
  parameter int WFIFO_DEPTH = 4
) (
  input logic              clk,
  input logic              rst,
  bcg_ram_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(WFIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(WFIFO_DEPTH);

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_DATA = 2'd2
  } rd_state_e;

  rd_state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_mem_q [WFIFO_DEPTH];
  logic [ADDR_W-1:0] addr_mem_d [WFIFO_DEPTH];
  logic [DATA_W-1:0] data_mem_q [WFIFO_DEPTH];
  logic [DATA_W-1:0] data_mem_d [WFIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;

  logic rd_pend, fifo_empty, pop, push, rd_acc, issue, ready;

  // Ready is judged on the current level only, so a full FIFO never accepts
  // a push even while it is draining in the same cycle.
  always_comb begin
    rd_pend    = (state_q != R_IDLE);
    fifo_empty = (level_q == '0);
    pop        = !bus.vid_active && !fifo_empty;
    issue      = (state_q == R_WAIT) && !bus.vid_active && fifo_empty;
    if (rd_pend)         ready = 1'b0;
    else if (bus.cpu_we) ready = (level_q < DEPTH_LVL);
    else                 ready = fifo_empty;
    push   = bus.cpu_req && ready && bus.cpu_we;
    rd_acc = bus.cpu_req && ready && !bus.cpu_we;
  end

  always_comb begin
    addr_mem_d = addr_mem_q;
    data_mem_d = data_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (push) begin
      addr_mem_d[wr_ptr_q] = bus.cpu_addr;
      data_mem_d[wr_ptr_q] = bus.cpu_wdata;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    level_d = level_q + LVL_W'(push) - LVL_W'(pop);
  end

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    case (state_q)
      R_IDLE: if (rd_acc) begin
        rd_addr_d = bus.cpu_addr;
        state_d   = R_WAIT;
      end
      R_WAIT: if (issue) state_d = R_DATA;
      R_DATA: state_d = R_IDLE;
      default: state_d = R_IDLE;
    endcase
  end

  // RAM data is captured in R_DATA even if the fetcher takes the port back.
  always_comb begin
    rvalid_d      = (state_q == R_DATA);
    rdata_d       = (state_q == R_DATA) ? bus.ram_q : rdata_q;
    bus.ram_addr  = '0;
    bus.ram_we    = 1'b0;
    bus.ram_wdata = '0;
    if (bus.vid_active) begin
      bus.ram_addr = bus.vid_addr;
    end else if (pop) begin
      bus.ram_addr  = addr_mem_q[rd_ptr_q];
      bus.ram_wdata = data_mem_q[rd_ptr_q];
      bus.ram_we    = 1'b1;
    end else if (state_q == R_WAIT) begin
      bus.ram_addr = rd_addr_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= R_IDLE;
      addr_mem_q <= '{default: '0};
      data_mem_q <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      rd_addr_q  <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_mem_q <= addr_mem_d;
      data_mem_q <= data_mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      rd_addr_q  <= rd_addr_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
    end
  end

  assign bus.cpu_ready   = ready;
  assign bus.cpu_rvalid  = rvalid_q;
  assign bus.cpu_rdata   = rdata_q;
  assign bus.wfifo_level = level_q;
  assign bus.vid_rdata   = bus.ram_q;
endmodule

// File: doc/bcg_ram_arbiter.md
# bcg_ram_arbiter

Owns the single port of the 8 KiB background RAM (tile map, tile patterns, UI nibbles, palette-select area) and shares it between the background fetcher and the CPU bus. The fetcher has absolute priority during active display. CPU writes are posted through a small FIFO and drained in blanking. CPU reads are single-outstanding and complete only after all posted writes have landed. Sits between the background fetcher, the CPU bus bridge and the synchronous RAM macro.

## Interface
- ADDR_W, 13, RAM address width
- DATA_W, 8, RAM data width
- WFIFO_DEPTH, 4, posted-write FIFO entries; power of 2, ≥2
- clk  in  1  system/pixel clock
- rst  in  1  asynchronous, active-low reset
- vid_active  in  1  fetcher owns RAM this cycle (active display window)
- vid_addr  in  ADDR_W  fetcher address; combinational from fetcher
- vid_rdata  out  DATA_W  = ram_q, passed straight through
- cpu_req  in  1  CPU transfer request
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ready  out  1  request accepted this cycle when cpu_req && cpu_ready
- cpu_rvalid  out  1  one-cycle pulse; cpu_rdata valid
- cpu_rdata  out  DATA_W  read data, held until next read completes
- wfifo_level  out  $clog2(WFIFO_DEPTH)+1  posted writes outstanding
- ram_addr  out  ADDR_W  RAM address (combinational mux)
- ram_we  out  1  RAM write enable
- ram_wdata  out  DATA_W  RAM write data
- ram_q  in  DATA_W  RAM read data; 1-cycle latency after address

## Operation
- Port mux, evaluated every cycle, priority order:
  - vid_active=1: ram_addr=vid_addr, ram_we=0.
  - Else, FIFO non-empty: pop head; ram_addr/ram_wdata from head; ram_we=1.
  - Else, read FSM in R_WAIT: ram_addr=held read address, ram_we=0.
  - Else: ram_addr=0, ram_we=0.
- Write acceptance: cpu_ready = !rd_pend && level<WFIFO_DEPTH. A full FIFO blocks the push even when a pop occurs in the same cycle. Push and pop in one cycle leaves the level unchanged. FIFO order is strictly preserved.
- Read acceptance: cpu_ready = !rd_pend && level==0, using the current-cycle level. No writes are accepted while a read is pending, so reads observe every earlier write.
- Read FSM (rd_pend = state≠R_IDLE):
  - R_IDLE: on accepted read, latch address → R_WAIT.
  - R_WAIT: if vid_active=0, drive the address (issue) → R_DATA; otherwise hold.
  - R_DATA: ram_q is valid regardless of vid_active. cpu_rdata<=ram_q, cpu_rvalid<=1 → R_IDLE.
- cpu_rvalid is high for exactly one cycle per read.
- ram_wdata must equal the FIFO head whenever ram_we=1. Its value is otherwise don't-care, but it must be deterministic.
- Pointers are $clog2(WFIFO_DEPTH) bits and wrap modulo depth. The level counter disambiguates full from empty.

## Timing
- Reset (rst low, async): FIFO emptied, level=0, FSM=R_IDLE, cpu_rvalid=0, cpu_rdata=0, ram_we=0. Any pending read is dropped with no rvalid.
- Write accepted at the end of cycle t: earliest RAM write is in cycle t+1 (if vid_active=0 in t+1).
- Read accepted at the end of cycle t, with vid_active=0: issue in t+1, R_DATA in t+2, cpu_rvalid=1 in t+3, cpu_ready for the next request in t+3.
- Each vid_active cycle during R_WAIT adds one cycle of latency. vid_active rising during R_DATA does not delay capture.
- vid_rdata latency equals RAM latency (1 cycle). The arbiter adds no stage on the video path.
- A request held during vid_active is still accepted if cpu_ready permits: writes are queued, reads wait in R_WAIT.

## Test plan
- Reset mid-read: accept read at 0x0100, assert rst low during R_DATA → cpu_rvalid stays 0, level=0, ram_we=0 after release.
- Blanking write then read: write 0x1A55←0x3C, read 0x1A55 with vid_active=0 → ram_we=1 one cycle after accept; read returns 0x3C with rvalid 3 cycles after accept.
- FIFO full under display: vid_active=1, push 5 writes (0x0000–0x0004, data 0x10–0x14) → 4 accepted, cpu_ready=0 on the 5th, level=4, no ram_we. Drop vid_active → 4 in-order writes on consecutive cycles, then the 5th is accepted.
- Read blocked by posted writes: 2 writes queued, read requested → cpu_ready=0 until level=0; returned data reflects both writes.
- Video priority: vid_active toggled 1,0,1,0 with a read in R_WAIT → issue occurs only in a vid_active=0 cycle; ram_addr=vid_addr in every vid_active=1 cycle; vid_rdata tracks ram_q.
- Simultaneous push/pop: level=2, vid_active=0, push accepted → level stays 2; pointer wrap after 9 writes preserves order.
